// File: rtl/scan_feeder.sv
// rtl/scan_feeder.sv - serialises one padded block into scan_in chunks clocked by a generated scan_clk
// then holds core enable until the round stage reports completion.
module scan_feeder #(
  parameter int CHUNK_W   = 136,
  parameter int CHUNKS    = 8,
  parameter int SCLK_HALF = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        blk_valid,
  input  logic [CHUNK_W*CHUNKS-1:0]   blk_data,
  output logic                        blk_ready,
  output logic [CHUNK_W-1:0]          scan_in,
  output logic                        scan_clk,
  output logic                        enable,
  input  logic                        core_done,
  output logic                        done
);

  localparam int BLK_W = CHUNK_W * CHUNKS;
  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PH_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(SCLK_HALF - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  logic [1:0]       state;
  logic [BLK_W-1:0] shreg;
  logic [CNT_W-1:0] chunk_cnt;
  logic [PH_W-1:0]  phase_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      chunk_cnt <= '0;
      phase_cnt <= '0;
      blk_ready <= 1'b0;
      scan_in   <= '0;
      scan_clk  <= 1'b0;
      enable    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (blk_valid && blk_ready) begin
            // The first chunk is presented on the same edge that enters LOW.
            shreg     <= blk_data;
            scan_in   <= blk_data[BLK_W-1 -: CHUNK_W];
            chunk_cnt <= '0;
            phase_cnt <= '0;
            blk_ready <= 1'b0;
            state     <= ST_LOW;
          end else begin
            blk_ready <= 1'b1;
          end
        end
        ST_LOW: begin
          if (phase_cnt == LAST_PHASE) begin
            phase_cnt <= '0;
            scan_clk  <= 1'b1;
            state     <= ST_HIGH;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (phase_cnt == LAST_PHASE) begin
            phase_cnt <= '0;
            scan_clk  <= 1'b0;
            if (chunk_cnt == LAST_CHUNK) begin
              enable <= 1'b1;
              state  <= ST_RUN;
            end else begin
              // Next chunk sits just below the top of the not-yet-shifted register.
              chunk_cnt <= chunk_cnt + 1'b1;
              shreg     <= shreg << CHUNK_W;
              scan_in   <= shreg[BLK_W-CHUNK_W-1 -: CHUNK_W];
              state     <= ST_LOW;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            enable    <= 1'b0;
            done      <= 1'b1;
            blk_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_feeder.sv
// tb/tb_scan_feeder.sv - bench for scan_feeder: default and SCLK_HALF=1 instances checked against
// a block/timing model and an input-buffer reconstruction monitor.
module tb_scan_feeder;
  localparam int CW = 136;
  localparam int NC = 8;
  localparam int BW = CW * NC;
  localparam int H0 = 2;
  localparam int H1 = 1;

  typedef struct {
    int inst;
    int d;
    bit toggle;
    bit pattern;
    bit b2b;
    int exp_en;
    int exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] blk_valid = 2'b00;
  logic [1:0] core_done = 2'b00;
  logic [1:0] blk_ready, scan_clk, enable, done;
  logic [BW-1:0] blk_data [2];
  logic [CW-1:0] scan_in [2];

  int vectors = 0;
  int miscompares = 0;

  int pulses [2] = '{0, 0};
  int viol [2] = '{0, 0};
  int stable [2] = '{0, 0};
  int hi_run [2] = '{0, 0};
  logic [BW-1:0] recon [2];
  logic [CW-1:0] prev_in [2];
  logic [1:0] prev_clk = 2'b00;

  always #5 clk = ~clk;

  scan_feeder #(.CHUNK_W(CW), .CHUNKS(NC), .SCLK_HALF(H0)) u_dut0 (
    .clk(clk), .reset(reset), .blk_valid(blk_valid[0]), .blk_data(blk_data[0]),
    .blk_ready(blk_ready[0]), .scan_in(scan_in[0]), .scan_clk(scan_clk[0]),
    .enable(enable[0]), .core_done(core_done[0]), .done(done[0])
  );

  scan_feeder #(.CHUNK_W(CW), .CHUNKS(NC), .SCLK_HALF(H1)) u_dut1 (
    .clk(clk), .reset(reset), .blk_valid(blk_valid[1]), .blk_data(blk_data[1]),
    .blk_ready(blk_ready[1]), .scan_in(scan_in[1]), .scan_clk(scan_clk[1]),
    .enable(enable[1]), .core_done(core_done[1]), .done(done[1])
  );

  function automatic int half(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  // Input-buffer model: captures scan_in on each scan_clk rise and flags timing violations.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        prev_clk[i] <= 1'b0;
        hi_run[i]   <= 0;
        stable[i]   <= 0;
      end else begin
        stable[i] <= (scan_in[i] == prev_in[i]) ? stable[i] + 1 : 1;
        hi_run[i] <= scan_clk[i] ? (prev_clk[i] ? hi_run[i] + 1 : 1) : 0;
        if (scan_clk[i] && !prev_clk[i]) begin
          pulses[i] <= pulses[i] + 1;
          recon[i]  <= {recon[i][BW-CW-1:0], scan_in[i]};
        end
        viol[i] <= viol[i] +
          (((scan_clk[i] && !prev_clk[i] && (scan_in[i] != prev_in[i] || stable[i] < half(i))) ||
            (scan_clk[i] && prev_clk[i] && scan_in[i] != prev_in[i]) ||
            (!scan_clk[i] && prev_clk[i] && hi_run[i] != half(i))) ? 1 : 0);
        prev_clk[i] <= scan_clk[i];
      end
      prev_in[i] <= scan_in[i];
    end
  end

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pattern_blk();
    logic [BW-1:0] b;
    logic [7:0] byt;
    b = '0;
    for (int k = 0; k < NC; k++) begin
      byt = 8'(k + 1);
      b[BW-1-CW*k -: CW] = {17{byt}};
    end
    return b;
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int j = 0; j < BW / 32; j++) b[j*32 +: 32] = $urandom;
    return b;
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_block(input int i, input logic [BW-1:0] blk, input int d, input bit toggle,
                           input bit b2b, input int exp_en, input int exp_lat, input string tag);
    int waitc, cyc, lat, en_cnt, p0, v0;
    bit got_done, done_en, done_rdy;
    waitc = 0; cyc = 0; lat = -1; en_cnt = 0;
    got_done = 0; done_en = 1'b1; done_rdy = 1'b0;
    p0 = pulses[i];
    v0 = viol[i];
    blk_data[i]  = blk;
    blk_valid[i] = 1'b1;
    if (d == 0) core_done[i] = 1'b1;
    while (!blk_ready[i] && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (b2b) check({tag, " accept_wait"}, CW'(waitc), CW'(0));
    check({tag, " accepted"}, CW'(waitc < 200), CW'(1));
    while (!got_done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (done[i]) begin
        got_done = 1'b1;
        done_en  = enable[i];
        done_rdy = blk_ready[i];
        blk_valid[i] = 1'b0;
      end else begin
        if (enable[i]) begin
          if (lat < 0) lat = cyc;
          en_cnt++;
          if (en_cnt == d) core_done[i] = 1'b1;
        end
        blk_valid[i] = toggle ? 1'($urandom) : 1'b0;
        blk_data[i]  = rand_blk();
      end
    end
    blk_valid[i] = 1'b0;
    core_done[i] = 1'b0;
    check({tag, " done_seen"}, CW'(got_done), CW'(1));
    check({tag, " enable_latency"}, CW'(lat), CW'(exp_lat));
    check({tag, " enable_cycles"}, CW'(en_cnt), CW'(exp_en));
    check({tag, " enable_at_done"}, CW'(done_en), CW'(0));
    check({tag, " ready_at_done"}, CW'(done_rdy), CW'(1));
    check({tag, " pulse_count"}, CW'(pulses[i] - p0), CW'(NC));
    check({tag, " scan_timing"}, CW'(viol[i] - v0), CW'(0));
    for (int k = 0; k < NC; k++)
      check($sformatf("%s chunk%0d", tag, k), recon[i][BW-1-CW*k -: CW], blk[BW-1-CW*k -: CW]);
  endtask

  initial begin
    vec_t tbl [6];
    logic [BW-1:0] blk;
    int p0, c, inst, d;
    bit any_clk;

    blk_data[0] = '0;
    blk_data[1] = '0;
    recon[0] = '0;
    recon[1] = '0;

    tbl[0] = '{inst: 0, d: 24, toggle: 0, pattern: 1, b2b: 0, exp_en: 24, exp_lat: 2*NC*H0+1};
    tbl[1] = '{inst: 0, d: 5,  toggle: 1, pattern: 1, b2b: 1, exp_en: 5,  exp_lat: 2*NC*H0+1};
    tbl[2] = '{inst: 0, d: 0,  toggle: 0, pattern: 1, b2b: 0, exp_en: 1,  exp_lat: 2*NC*H0+1};
    tbl[3] = '{inst: 1, d: 3,  toggle: 1, pattern: 1, b2b: 0, exp_en: 3,  exp_lat: 17};
    tbl[4] = '{inst: 1, d: 1,  toggle: 1, pattern: 0, b2b: 0, exp_en: 1,  exp_lat: 17};
    tbl[5] = '{inst: 1, d: 0,  toggle: 0, pattern: 0, b2b: 0, exp_en: 1,  exp_lat: 17};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset blk_ready%0d", i), CW'(blk_ready[i]), CW'(0));
      check($sformatf("reset scan_clk%0d", i), CW'(scan_clk[i]), CW'(0));
      check($sformatf("reset enable%0d", i), CW'(enable[i]), CW'(0));
      check($sformatf("reset done%0d", i), CW'(done[i]), CW'(0));
      check($sformatf("reset scan_in%0d", i), scan_in[i], CW'(0));
    end
    reset = 1'b1;
    #1 check("ready before first edge", CW'(blk_ready), CW'(0));
    @(negedge clk);
    check("ready after first edge", CW'(blk_ready), CW'(2'b11));
    p0 = pulses[0] + pulses[1];
    any_clk = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any_clk = any_clk | (|scan_clk) | (|enable);
    end
    check("idle scan_clk quiet", CW'(any_clk), CW'(0));
    check("idle pulse count", CW'(pulses[0] + pulses[1] - p0), CW'(0));

    for (int r = 0; r < 6; r++) begin
      if (!tbl[r].b2b) begin
        @(negedge clk);
        check($sformatf("row%0d done_low", r), CW'(done), CW'(0));
        repeat (3) @(negedge clk);
      end
      blk = tbl[r].pattern ? pattern_blk() : rand_blk();
      run_block(tbl[r].inst, blk, tbl[r].d, tbl[r].toggle, tbl[r].b2b,
                tbl[r].exp_en, tbl[r].exp_lat, $sformatf("row%0d", r));
    end

    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      inst = $urandom_range(0, 1);
      d = $urandom_range(0, 30);
      run_block(inst, rand_blk(), d, 1'($urandom), 1'b0,
                (d == 0) ? 1 : d, 2*NC*half(inst)+1, $sformatf("rnd%0d", n));
    end

    // Reset while the third chunk is being clocked in.
    @(negedge clk);
    p0 = pulses[0];
    blk_data[0] = pattern_blk();
    blk_valid[0] = 1'b1;
    c = 0;
    while (!blk_ready[0] && c < 200) begin @(negedge clk); c++; end
    @(negedge clk);
    blk_valid[0] = 1'b0;
    c = 0;
    while (pulses[0] - p0 < 3 && c < 200) begin @(negedge clk); c++; end
    check("midreset third pulse reached", CW'(pulses[0] - p0), CW'(3));
    check("midreset scan_clk high", CW'(scan_clk[0]), CW'(1));
    #1 reset = 1'b0;
    #1;
    check("midreset scan_clk", CW'(scan_clk[0]), CW'(0));
    check("midreset enable", CW'(enable[0]), CW'(0));
    check("midreset scan_in", scan_in[0], CW'(0));
    check("midreset blk_ready", CW'(blk_ready[0]), CW'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post reset ready", CW'(blk_ready), CW'(2'b11));
    run_block(0, rand_blk(), 7, 1'b1, 1'b0, 7, 2*NC*H0+1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
